// File: rtl/multimode_waveform_generator.sv
// -----------------------------------------------------------------------------
// multimode_waveform_generator
//
// Runtime-configurable waveform source for the R2R DAC path. Produces
// sawtooth-up, sawtooth-down, triangle and square waves as a WIDTH-bit code.
// Each output step lasts step_period clock cycles (0 behaves like 1).
//
// Handshake/flow: there is no valid/ready pair here. R2R_output is a
// free-running registered code. cycle_done is a single-cycle strobe that is
// aligned with the output code that starts the next waveform period.
//
// Optional build macro: WAVEGEN_AMPLITUDE_EN
//   defined   : adds the amplitude input. The output becomes
//               (code*(amplitude+1))>>WIDTH through one extra register stage.
//               R2R_output and cycle_done are both delayed one clock and stay
//               aligned with each other.
//   undefined : there is no amplitude port, and R2R_output is the raw code.
//
// Ports
//   clk          in   1             system clock, rising edge
//   reset        in   1             synchronous, active-high
//   enable       in   1             run generator; low holds the idle state
//   mode         in   2             00 saw-up, 01 saw-down, 10 triangle, 11 square
//   step_period  in   PERIOD_WIDTH  clk cycles per output step (0 treated as 1)
//   amplitude    in   WIDTH         output scale (WAVEGEN_AMPLITUDE_EN only)
//   R2R_output   out  WIDTH         DAC code, registered
//   cycle_done   out  1             1-clk pulse at each waveform period boundary
// -----------------------------------------------------------------------------
module multimode_waveform_generator #(
    parameter int WIDTH        = 8,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [PERIOD_WIDTH-1:0] step_period,
`ifdef WAVEGEN_AMPLITUDE_EN
    input  logic [WIDTH-1:0]        amplitude,
`endif
    output logic [WIDTH-1:0]        R2R_output,
    output logic                    cycle_done
);

    localparam logic [1:0] MODE_SAW_UP   = 2'b00;
    localparam logic [1:0] MODE_SAW_DOWN = 2'b01;
    localparam logic [1:0] MODE_TRIANGLE = 2'b10;
    localparam logic [1:0] MODE_SQUARE   = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [WIDTH-1:0] MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MAX_M1 = MAX - 1'b1;
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] limit;
    logic [WIDTH-1:0]        phase;
    logic [WIDTH-1:0]        phase_nxt;
    logic                    dir;
    logic                    dir_nxt;
    logic [1:0]              mode_q;
    logic                    step;
    logic                    wrap;
    logic                    mode_change;
    logic [WIDTH-1:0]        code_q;
    logic                    done_q;

    // Map a phase value to the DAC code for a given mode. For saw-down the
    // phase still counts up. The code is its complement, so phase 0 gives MAX.
    function automatic logic [WIDTH-1:0] code_of(input logic [1:0]       m,
                                                 input logic [WIDTH-1:0] p);
        case (m)
            MODE_SAW_DOWN: code_of = MAX - p;
            MODE_SQUARE:   code_of = p[WIDTH-1] ? MAX : '0;
            default:       code_of = p;
        endcase
    endfunction

    // step_period is compared live. If the period is lowered below the
    // current count, a step is forced on the very next edge.
    assign limit       = (step_period == '0) ? '0 : step_period - 1'b1;
    assign step        = (cnt >= limit);
    assign mode_change = (mode != mode_q);

    always_comb begin
        phase_nxt = phase;
        dir_nxt   = dir;
        wrap      = 1'b0;
        if (step) begin
            if (mode_q == MODE_TRIANGLE) begin
                if (dir == DIR_UP) begin
                    phase_nxt = phase + 1'b1;
                    if (phase == MAX_M1) begin
                        dir_nxt = DIR_DOWN;
                    end
                end else begin
                    phase_nxt = phase - 1'b1;
                    // The 1->0 step closes a triangle period.
                    if (phase == ONE) begin
                        dir_nxt = DIR_UP;
                        wrap    = 1'b1;
                    end
                end
            end else begin
                // Saw-up, saw-down and square all use a wrapping ramp phase.
                phase_nxt = phase + 1'b1;
                wrap      = (phase == MAX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt    <= '0;
            phase  <= '0;
            dir    <= DIR_UP;
            mode_q <= mode;
            code_q <= '0;
            done_q <= 1'b0;
        end else if (mode_change) begin
            // Restart in the new mode. Any coincident step is dropped.
            cnt    <= '0;
            phase  <= '0;
            dir    <= DIR_UP;
            mode_q <= mode;
            code_q <= code_of(mode, '0);
            done_q <= 1'b0;
        end else begin
            cnt    <= step ? '0 : cnt + 1'b1;
            phase  <= phase_nxt;
            dir    <= dir_nxt;
            code_q <= code_of(mode_q, phase_nxt);
            done_q <= wrap;
        end
    end

`ifdef WAVEGEN_AMPLITUDE_EN
    logic [WIDTH:0]       amp_p1;
    logic [2*WIDTH-1:0]   product;

    assign amp_p1  = {1'b0, amplitude} + 1'b1;
    assign product = {{WIDTH{1'b0}}, code_q} * {{(WIDTH-1){1'b0}}, amp_p1};

    always_ff @(posedge clk) begin
        if (reset) begin
            R2R_output <= '0;
            cycle_done <= 1'b0;
        end else begin
            R2R_output <= product[2*WIDTH-1:WIDTH];
            cycle_done <= done_q;
        end
    end
`else
    assign R2R_output = code_q;
    assign cycle_done = done_q;
`endif

endmodule

// File: tb/tb_multimode_waveform_generator.sv
// -----------------------------------------------------------------------------
// tb_multimode_waveform_generator
//
// Bench for multimode_waveform_generator with WIDTH=4.
// The reference model tracks the number of steps taken since the last restart,
// and derives the code and period boundary from that count arithmetically.
// Directed literal expectations pin the model. A long randomized run follows.
// -----------------------------------------------------------------------------
module tb_multimode_waveform_generator;

    localparam int W    = 4;
    localparam int PW   = 24;
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [1:0]    mode;
    logic [PW-1:0] step_period;
`ifdef WAVEGEN_AMPLITUDE_EN
    logic [W-1:0]  amplitude;
`endif
    logic [W-1:0]  R2R_output;
    logic          cycle_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multimode_waveform_generator #(.WIDTH(W), .PERIOD_WIDTH(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .step_period (step_period),
`ifdef WAVEGEN_AMPLITUDE_EN
        .amplitude   (amplitude),
`endif
        .R2R_output  (R2R_output),
        .cycle_done  (cycle_done)
    );

    // ---------------- reference model ----------------
    int         m_cnt;
    int         m_steps;
    logic [1:0] m_mode;
    int         m_out;
    bit         m_done;
    int         e_out;
    bit         e_done;
    bit         model_valid = 1'b0;

    function automatic int period_of(input logic [1:0] md);
        return (md == 2'b10) ? 2 * MAXV : MAXV + 1;
    endfunction

    function automatic int code_for(input logic [1:0] md, input int steps);
        int p;
        p = steps % period_of(md);
        case (md)
            2'b00:   return p;
            2'b01:   return MAXV - p;
            2'b10:   return (p <= MAXV) ? p : 2 * MAXV - p;
            default: return (p >= (MAXV + 1) / 2) ? MAXV : 0;
        endcase
    endfunction

    always @(posedge clk) begin
        int eff;
`ifdef WAVEGEN_AMPLITUDE_EN
        if (reset) begin
            e_out  = 0;
            e_done = 1'b0;
        end else begin
            e_out  = (m_out * (int'(amplitude) + 1)) >> W;
            e_done = m_done;
        end
`endif
        if (reset || !enable) begin
            m_cnt   = 0;
            m_steps = 0;
            m_mode  = mode;
            m_out   = 0;
            m_done  = 1'b0;
        end else if (mode != m_mode) begin
            m_mode  = mode;
            m_cnt   = 0;
            m_steps = 0;
            m_out   = code_for(mode, 0);
            m_done  = 1'b0;
        end else begin
            eff = (step_period == 0) ? 1 : int'(step_period);
            if (m_cnt >= eff - 1) begin
                m_cnt   = 0;
                m_steps = m_steps + 1;
                m_done  = (m_steps % period_of(m_mode)) == 0;
            end else begin
                m_cnt   = m_cnt + 1;
                m_done  = 1'b0;
            end
            m_out = code_for(m_mode, m_steps);
        end
`ifndef WAVEGEN_AMPLITUDE_EN
        e_out  = m_out;
        e_done = m_done;
`endif
        model_valid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (R2R_output !== e_out[W-1:0]) begin
                errors++;
                $display("FAIL model_out t=%0t got=%0d exp=%0d", $time, R2R_output, e_out);
            end
            checks++;
            if (cycle_done !== e_done) begin
                errors++;
                $display("FAIL model_done t=%0t got=%0b exp=%0b", $time, cycle_done, e_done);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
`ifndef WAVEGEN_AMPLITUDE_EN
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
        end
`endif
    endtask

    task automatic wait_done(input string name, input int limit, output int n);
        bit timed_out;
        n = 0;
        timed_out = 1'b1;
        while (n < limit) begin
            tick();
            n++;
            if (cycle_done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout t=%0t waited=%0d", name, $time, n);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit found;
        reset       = 1'b1;
        enable      = 1'b1;
        mode        = 2'b00;
        step_period = 3;
`ifdef WAVEGEN_AMPLITUDE_EN
        amplitude   = MAXV[W-1:0];
`endif
        repeat (5) begin
            tick();
            check_lit("reset_out", R2R_output, 0);
            check_lit("reset_done", cycle_done, 0);
        end
        reset = 1'b0;

        // Saw-up: one wrap every 16 steps of 3 clocks.
        wait_done("sawup1", 200, n);
        check_lit("sawup_first_period", n, 48);
        check_lit("sawup_wrap_code", R2R_output, 0);
        wait_done("sawup2", 200, n);
        check_lit("sawup_period", n, 48);

        // Triangle: 30 steps per period. The restart edge adds one to the first interval.
        mode = 2'b10;
        wait_done("tri1", 300, n);
        check_lit("tri_first_period", n, 91);
        wait_done("tri2", 300, n);
        check_lit("tri_period", n, 90);

        // Saw-down from idle: first running code is MAX.
        enable = 1'b0;
        mode   = 2'b01;
        tick();
        check_lit("idle_out", R2R_output, 0);
        enable = 1'b1;
        tick();
        check_lit("sawdown_first", R2R_output, 15);
        tick();
        check_lit("sawdown_hold", R2R_output, 15);
        tick();
        check_lit("sawdown_second", R2R_output, 14);

        // Square: 24 clocks low, then high.
        mode = 2'b11;
        tick();
        check_lit("square_start", R2R_output, 0);
        repeat (23) tick();
        check_lit("square_low_end", R2R_output, 0);
        tick();
        check_lit("square_high", R2R_output, 15);
        repeat (24) tick();
        check_lit("square_wrap_out", R2R_output, 0);
        check_lit("square_wrap_done", cycle_done, 1);

        // Mode change mid-ramp restarts at the new mode's start code.
        mode = 2'b00;
        tick();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (R2R_output == 4'd9) begin
                found = 1'b1;
                break;
            end
        end
        check_lit("reach_code9", found, 1);
        mode = 2'b10;
        tick();
        check_lit("modechg_out", R2R_output, 0);
        check_lit("modechg_done", cycle_done, 0);
        repeat (9) tick();
        check_lit("tri_ramp3", R2R_output, 3);
        enable = 1'b0;
        tick();
        check_lit("disable_out", R2R_output, 0);

        // Live step_period changes.
        mode        = 2'b00;
        step_period = 100;
        enable      = 1'b1;
        repeat (50) tick();
        check_lit("long_period_hold", R2R_output, 0);
        step_period = 2;
        tick();
        check_lit("period_drop_step", R2R_output, 1);
        step_period = 0;
        tick();
        check_lit("period0_a", R2R_output, 2);
        tick();
        check_lit("period0_b", R2R_output, 3);
        step_period = 1;
        tick();
        check_lit("period1", R2R_output, 4);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 63) == 0);
            enable = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) step_period = PW'($urandom_range(0, 4));
`ifdef WAVEGEN_AMPLITUDE_EN
            if ($urandom_range(0, 49) == 0) amplitude = W'($urandom_range(0, MAXV));
`endif
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
